// File: rtl/vqueue_sync.sv
// vqueue_sync: single-clock FIFO with occupancy, thresholds, sticky error flags, flush and optional FWFT read
module vqueue_sync #(
  parameter int data_width = 32,
  parameter int addr_width = 11,
  parameter int ae_thresh  = 32,
  parameter int af_thresh  = 2**addr_width - 32,
  parameter int fwft       = 0
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Flush,
  input  logic                  WrEn,
  input  logic [data_width-1:0] Data,
  input  logic                  RdEn,
  output logic [data_width-1:0] Q,
  output logic                  QValid,
  output logic                  Empty,
  output logic                  Full,
  output logic                  AlmostEmpty,
  output logic                  AlmostFull,
  output logic [addr_width:0]   Level,
  output logic                  Overflow,
  output logic                  Underflow
);
  localparam logic [addr_width:0] depth = {1'b1, {addr_width{1'b0}}};
  localparam logic [addr_width:0] one   = (addr_width+1)'(1);
  localparam logic [addr_width:0] ae_l  = (addr_width+1)'(ae_thresh);
  localparam logic [addr_width:0] af_l  = (addr_width+1)'(af_thresh);
  localparam bit params_ok = ae_thresh > 0 && ae_thresh <= af_thresh && af_thresh <= 2**addr_width;
  logic [data_width-1:0] mem [2**addr_width];
  logic [addr_width:0] wr_ptr, rd_ptr;
  logic wr_acc;
  assign Level       = wr_ptr - rd_ptr;
  assign Full        = Level == depth;
  assign AlmostEmpty = Level < ae_l;
  assign AlmostFull  = Level >= af_l;
  assign wr_acc      = WrEn && !Full && !Flush;
  always @(posedge Clock) assert (params_ok) else $error("vqueue_sync: illegal thresholds");
  always_ff @(posedge Clock)
    if (wr_acc) mem[wr_ptr[addr_width-1:0]] <= Data;
  always_ff @(posedge Clock or negedge ResetN)
    if (!ResetN) begin
      wr_ptr   <= '0;
      Overflow <= 1'b0;
    end else if (Flush) begin
      wr_ptr   <= '0;
      Overflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + one;
      Overflow <= Overflow | (WrEn && Full);
    end
  if (fwft == 0) begin : g_std
    logic rd_acc;
    assign Empty  = Level == '0;
    assign rd_acc = RdEn && !Empty && !Flush;
    always_ff @(posedge Clock or negedge ResetN)
      if (!ResetN) begin
        rd_ptr    <= '0;
        Q         <= '0;
        QValid    <= 1'b0;
        Underflow <= 1'b0;
      end else if (Flush) begin
        rd_ptr    <= '0;
        QValid    <= 1'b0;
        Underflow <= 1'b0;
      end else begin
        if (rd_acc) begin
          rd_ptr <= rd_ptr + one;
          Q      <= mem[rd_ptr[addr_width-1:0]];
        end
        QValid    <= rd_acc;
        Underflow <= Underflow | (RdEn && Empty);
      end
  end else begin : g_fwft
    // rd_ptr tracks pops so Level includes the staged and presented words; f_ptr tracks RAM fetches
    logic [addr_width:0]   f_ptr;
    logic [data_width-1:0] s1_data;
    logic s1_valid, pop, q_load, fetch;
    assign Empty  = !QValid;
    assign pop    = RdEn && QValid;
    assign q_load = (!QValid || pop) && s1_valid;
    assign fetch  = (!s1_valid || q_load) && f_ptr != wr_ptr;
    always_ff @(posedge Clock or negedge ResetN)
      if (!ResetN) begin
        rd_ptr    <= '0;
        f_ptr     <= '0;
        s1_data   <= '0;
        s1_valid  <= 1'b0;
        Q         <= '0;
        QValid    <= 1'b0;
        Underflow <= 1'b0;
      end else if (Flush) begin
        rd_ptr    <= '0;
        f_ptr     <= '0;
        s1_valid  <= 1'b0;
        QValid    <= 1'b0;
        Underflow <= 1'b0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + one;
        if (fetch) begin
          f_ptr   <= f_ptr + one;
          s1_data <= mem[f_ptr[addr_width-1:0]];
        end
        if (q_load) Q <= s1_data;
        s1_valid  <= fetch || (s1_valid && !q_load);
        QValid    <= q_load || (QValid && !pop);
        Underflow <= Underflow | (RdEn && !QValid);
      end
  end
endmodule

// File: tb/tb_vqueue_sync.sv
// tb_vqueue_sync: standard and FWFT instances driven together, checked against queue-based reference models
module tb_vqueue_sync;
  logic clk = 0, rst_n, flush, wr_en, rd_en;
  logic [31:0] data, q_s, q_f;
  logic qv_s, emp_s, full_s, ae_s, af_s, ovf_s, unf_s;
  logic qv_f, emp_f, full_f, ae_f, af_f, ovf_f, unf_f;
  logic [4:0] lvl_s, lvl_f;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [31:0] d; int w;} fw_t;
  logic [31:0] sq[$];
  fw_t fq[$];
  logic [31:0] s_eq, f_eq;
  bit s_qv, s_ovf, s_unf, f_ovf, f_unf;
  always #5 clk = ~clk;
  vqueue_sync #(.data_width(32), .addr_width(4), .ae_thresh(4), .af_thresh(12), .fwft(0)) u_std (
    .Clock(clk), .ResetN(rst_n), .Flush(flush), .WrEn(wr_en), .Data(data), .RdEn(rd_en),
    .Q(q_s), .QValid(qv_s), .Empty(emp_s), .Full(full_s), .AlmostEmpty(ae_s), .AlmostFull(af_s),
    .Level(lvl_s), .Overflow(ovf_s), .Underflow(unf_s));
  vqueue_sync #(.data_width(32), .addr_width(4), .ae_thresh(4), .af_thresh(12), .fwft(1)) u_fw (
    .Clock(clk), .ResetN(rst_n), .Flush(flush), .WrEn(wr_en), .Data(data), .RdEn(rd_en),
    .Q(q_f), .QValid(qv_f), .Empty(emp_f), .Full(full_f), .AlmostEmpty(ae_f), .AlmostFull(af_f),
    .Level(lvl_f), .Overflow(ovf_f), .Underflow(unf_f));
  // a FWFT word is presented once it heads the queue and was written at least two edges ago
  function automatic bit fvis();
    return fq.size() > 0 && fq[0].w + 2 <= cyc;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    bit v = fvis();
    chk("s_level", lvl_s, sq.size());
    chk("s_full", full_s, sq.size() == 16);
    chk("s_empty", emp_s, sq.size() == 0);
    chk("s_ae", ae_s, sq.size() < 4);
    chk("s_af", af_s, sq.size() >= 12);
    chk("s_ovf", ovf_s, s_ovf);
    chk("s_unf", unf_s, s_unf);
    chk("s_qvalid", qv_s, s_qv);
    chk("s_q", q_s, s_eq);
    chk("f_level", lvl_f, fq.size());
    chk("f_full", full_f, fq.size() == 16);
    chk("f_empty", emp_f, !v);
    chk("f_ae", ae_f, fq.size() < 4);
    chk("f_af", af_f, fq.size() >= 12);
    chk("f_ovf", ovf_f, f_ovf);
    chk("f_unf", unf_f, f_unf);
    chk("f_qvalid", qv_f, v);
    chk("f_q", q_f, f_eq);
  endtask
  task automatic model_reset();
    sq.delete();
    fq.delete();
    {s_qv, s_ovf, s_unf, f_ovf, f_unf} = '0;
    s_eq = '0;
    f_eq = '0;
  endtask
  task automatic step(input bit wr, input bit rd, input bit fl, input logic [31:0] d);
    bit sfull, sempty, ffull, fv;
    wr_en = wr; rd_en = rd; flush = fl; data = d;
    sfull = sq.size() == 16;
    sempty = sq.size() == 0;
    ffull = fq.size() == 16;
    fv = fvis();
    @(posedge clk);
    cyc++;
    if (fl) begin
      sq.delete();
      fq.delete();
      {s_qv, s_ovf, s_unf, f_ovf, f_unf} = '0;
    end else begin
      s_qv = rd && !sempty;
      if (s_qv) s_eq = sq.pop_front();
      if (wr && !sfull) sq.push_back(d);
      s_ovf |= wr && sfull;
      s_unf |= rd && sempty;
      if (rd && fv) void'(fq.pop_front());
      if (wr && !ffull) fq.push_back('{d, cyc});
      f_ovf |= wr && ffull;
      f_unf |= rd && !fv;
    end
    if (fvis()) f_eq = fq[0].d;
    #1 check_all();
  endtask
  initial begin
    rst_n = 0; flush = 0; wr_en = 0; rd_en = 0; data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    rst_n = 1;
    for (int i = 0; i < 17; i++) step(1, 0, 0, i);
    for (int i = 0; i < 17; i++) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, $urandom);
    for (int i = 0; i < 100; i++) step(1, 1, 0, $urandom);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 32'hA5A5A5A5);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, $urandom);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, $urandom);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 1, 32'h1234);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) < (i < 200 ? 3 : 1), $urandom_range(0, 3) < (i < 200 ? 1 : 3),
           $urandom_range(0, 63) == 0, $urandom);
    step(0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, $urandom);
    #2 rst_n = 0;
    #1 model_reset();
    check_all();
    #1 rst_n = 1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, $urandom);
    step(0, 1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
